// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state type and default width shared by alu_arbiter and alu.
package alu_pkg;
  localparam int DATA_W_DEF = 32;
  localparam logic [1:0] OP_ADD = 2'b11;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b00;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/and/zero unit, wrapping modulo 2^DATA_W.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        con,
  output logic [DATA_W-1:0] c
);
  assign c = con == OP_ADD ? a + b : con == OP_SUB ? a - b : con == OP_AND ? a & b : '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one alu, one operation in flight, round-robin grant.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_con,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_con,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_c
);
  state_t state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, alu_c;
  logic [1:0] con_q, con_d;
  logic id_q, id_d, gnt0, gnt1, take;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic last_q, last_d;
`endif
  alu #(.DATA_W(DATA_W)) u_alu (.a(a_q), .b(b_q), .c(alu_c), .con(con_q));
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    gnt1 = req1_valid && !req0_valid;
`else
    gnt1 = req1_valid && (!req0_valid || !last_q);
    last_d = take ? gnt1 : last_q;
`endif
    gnt0 = req0_valid && !gnt1;
    take = state_q == IDLE && (gnt0 || gnt1);
    state_d = state_q == IDLE ? (take ? EXEC : IDLE)
            : state_q == EXEC ? RESP
            : (resp_ready ? IDLE : RESP);
    a_d = take ? (gnt1 ? req1_a : req0_a) : a_q;
    b_d = take ? (gnt1 ? req1_b : req0_b) : b_q;
    con_d = take ? (gnt1 ? req1_con : req0_con) : con_q;
    id_d = take ? gnt1 : id_q;
    c_d = state_q == EXEC ? alu_c : c_q;
  end
  assign req0_ready = !reset && take && gnt0;
  assign req1_ready = !reset && take && gnt1;
  assign resp_valid = !reset && state_q == RESP;
  assign resp_id = id_q;
  assign resp_c = c_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      c_q <= '0;
      id_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      id_q <= id_d;
    end
  end
  always_ff @(posedge clock) begin
    a_q <= a_d;
    b_q <= b_d;
    con_q <= con_d;
  end
`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b1;
    else last_q <= last_d;
  end
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random transactions checked against a behavioural model.
module tb_alu_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
  logic req0_ready, req1_ready, resp_valid, resp_id;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0, resp_c;
  logic [1:0] req0_con = '0, req1_con = '0;
  int n_chk = 0, n_fail = 0, last_m = 1;

  alu_arbiter #(.DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_con(req0_con),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_con(req1_con),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_c(resp_c)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] con);
    longint unsigned m = 64'd1 << 32;
    case (con)
      2'b11: return 32'((longint'(a) + longint'(b)) % m);
      2'b10: return 32'((longint'(a) + m - longint'(b)) % m);
      2'b00: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int winner(input bit v0, input bit v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 0 : 1;
`else
    if (v0 && v1) return last_m == 1 ? 0 : 1;
    return v0 ? 0 : 1;
`endif
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_c", resp_c, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
    last_m = 1;
  endtask

  task automatic txn(input bit v0, input bit v1, input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] c0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] c1, input int stall);
    int w;
    logic [31:0] e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_con = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_con = c1;
    resp_ready = (stall == 0);
    #1;
    w = winner(v0, v1);
    e = w == 1 ? ref_op(a1, b1, c1) : ref_op(a0, b0, c0);
    chk("grant_rdy0", 32'(req0_ready), 32'(w == 0));
    chk("grant_rdy1", 32'(req1_ready), 32'(w == 1));
    last_m = w;
    @(posedge clock); #1;
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    req0_con = 2'($urandom); req1_con = 2'($urandom);
    #1;
    chk("exec_rdy", 32'(req0_ready | req1_ready), 32'd0);
    chk("exec_valid", 32'(resp_valid), 32'd0);
    @(posedge clock); #1;
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_c", resp_c, e);
    chk("resp_id", 32'(resp_id), 32'(w));
    chk("resp_rdy", 32'(req0_ready | req1_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_c", resp_c, e);
      chk("stall_id", 32'(resp_id), 32'(w));
      chk("stall_rdy", 32'(req0_ready | req1_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("done_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    do_reset();
    txn(1, 0, 32'd9, 32'd5, 2'b11, 32'd0, 32'd0, 2'b00, 0);
    txn(0, 1, 32'd0, 32'd0, 2'b00, 32'd9, 32'd5, 2'b10, 0);
    txn(0, 1, 32'd0, 32'd0, 2'b00, 32'd9, 32'd5, 2'b00, 0);
    txn(0, 1, 32'd0, 32'd0, 2'b00, 32'd9, 32'd5, 2'b01, 0);
    txn(1, 0, 32'hFFFFFFFF, 32'd1, 2'b11, 32'd0, 32'd0, 2'b00, 0);
    txn(0, 1, 32'd0, 32'd0, 2'b00, 32'd0, 32'd1, 2'b10, 0);
    txn(1, 0, 32'h1234, 32'h0F0F, 2'b11, 32'd0, 32'd0, 2'b00, 4);
    do_reset();
    for (int i = 0; i < 4; i++)
      txn(1, 1, 32'd100 + 32'(i), 32'd3, 2'b11, 32'd200 + 32'(i), 32'd3, 2'b10, 0);
    req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7; req0_con = 2'b11;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_exec_rdy", 32'(req0_ready | req1_ready), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    last_m = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("rst_exec_novalid", 32'(resp_valid), 32'd0);
    end
    txn(1, 0, 32'd20, 32'd22, 2'b11, 32'd0, 32'd0, 2'b00, 0);
    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      txn(v0, v1, $urandom, $urandom, 2'($urandom), $urandom, $urandom, 2'($urandom), int'($urandom_range(0, 2)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
